// File: rtl/note_highway_pkg.sv
// Lane definitions shared by the note highway and the guitar scoring logic.
// Lane 0 is green and sits in bit 0 of every lane mask.
package note_highway_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        LANE_GREEN  = 2'd0,
        LANE_RED    = 2'd1,
        LANE_YELLOW = 2'd2,
        LANE_BLUE   = 2'd3
    } lane_e;

    typedef logic [LANES-1:0] lane_mask_t;

endpackage

// File: rtl/note_highway_tick_divider.sv
// Free-running scroll divider: asserts step for one cycle every TICK_DIV enabled cycles.
// The count holds while enable is low, so a paused game resumes mid-interval.
module tick_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic step
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign step = enable && (cnt_reg == LAST);

    always_comb begin
        cnt_next = cnt_reg;
        if (enable) begin
            cnt_next = step ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/note_highway.sv
// Scrolling 4-lane note highway: chart rows enter at row 0, the strike row drives
// intersections, hits clear strike-row notes and unhit departures are counted as misses.
module note_highway
    import note_highway_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000,
    parameter int MISS_W   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       chart_valid,
    input  logic [LANES-1:0]           chart_row,
    output logic                       chart_ready,
    input  logic                       hit_valid,
    input  logic [LANES-1:0]           hit_lanes,
    output logic [LANES-1:0]           intersections,
    output logic                       tick,
    output logic                       miss_pulse,
    output logic [MISS_W-1:0]          miss_count,
    output logic                       starve_pulse,
    input  logic [$clog2(DEPTH)-1:0]   disp_row,
    output logic [LANES-1:0]           disp_lanes
);

    localparam int  IDX_W = $clog2(DEPTH);
    localparam bit  POW2  = ((1 << IDX_W) == DEPTH);

    logic                        step;
    logic                        fire;
    lane_mask_t                  hit_mask;
    lane_mask_t                  departing;
    logic [2:0]                  departing_cnt;
    logic [MISS_W:0]             miss_sum;
    logic [DEPTH-1:0][LANES-1:0] rows_reg;
    logic [DEPTH-1:0][LANES-1:0] rows_next;
    logic                        tick_reg;
    logic                        miss_pulse_reg;
    logic                        starve_pulse_reg;
    logic [MISS_W-1:0]           miss_count_reg;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .step   (step)
    );

    assign chart_ready = step;
    assign fire        = chart_valid && step;
    assign hit_mask    = hit_valid ? hit_lanes : '0;
    assign departing   = rows_reg[DEPTH-1] & ~hit_mask;

    assign departing_cnt = ({2'b00, departing[0]} + {2'b00, departing[1]})
                         + ({2'b00, departing[2]} + {2'b00, departing[3]});
    assign miss_sum      = {1'b0, miss_count_reg} + (MISS_W+1)'(departing_cnt);

    // On a scroll the strike row is replaced unmasked; hits only mask what departs.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
            if (gi == 0) begin : g_entry
                assign rows_next[gi] = step ? (fire ? chart_row : '0) : rows_reg[gi];
            end else if (gi == DEPTH-1) begin : g_strike
                assign rows_next[gi] = step ? rows_reg[gi-1] : (rows_reg[gi] & ~hit_mask);
            end else begin : g_mid
                assign rows_next[gi] = step ? rows_reg[gi-1] : rows_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            rows_reg         <= '0;
            tick_reg         <= 1'b0;
            miss_pulse_reg   <= 1'b0;
            starve_pulse_reg <= 1'b0;
            miss_count_reg   <= '0;
        end else begin
            rows_reg         <= rows_next;
            tick_reg         <= step;
            miss_pulse_reg   <= step && (|departing);
            starve_pulse_reg <= step && !chart_valid;
            if (step) begin
                miss_count_reg <= miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
            end
        end
    end

    assign intersections = rows_reg[DEPTH-1];
    assign tick          = tick_reg;
    assign miss_pulse    = miss_pulse_reg;
    assign starve_pulse  = starve_pulse_reg;
    assign miss_count    = miss_count_reg;

    generate
        if (POW2) begin : g_disp_full
            assign disp_lanes = rows_reg[disp_row];
        end else begin : g_disp_guard
            assign disp_lanes = ({1'b0, disp_row} < (IDX_W+1)'(DEPTH)) ? rows_reg[disp_row] : '0;
        end
    endgenerate

endmodule
